// File: rtl/cache_trace_pkg.sv
// cache_trace_pkg
//   Shared types and helpers for the cache trace capture block.
//   - trace_state_e : capture FSM states
//   - onehot_chk    : exactly-one-bit-set test for the way-hit vector
//   The trace entry struct {tag, addr, data} depends on the capture module's
//   ADDR_W/DATA_W parameters, so it is declared inside that module.
//   Optional build macro used by this block: CACHE_TRACE_STATE_LOG_EN.
package cache_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } trace_state_e;

    // Callers zero-extend narrower vectors; the v & (v-1) trick clears the
    // lowest set bit, so a non-zero vector with nothing left was one-hot.
    function automatic logic onehot_chk(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/cache_trace_satcnt.sv
// cache_trace_satcnt
//   CNT_W-bit saturating up-counter.
//   Ports:
//     clk    in   clock
//     reset  in   synchronous active-high reset (counter -> 0)
//     clr_i  in   synchronous clear
//     inc_i  in   increment request; ignored once the counter is all-ones
//     cnt_o  out  current count
module cache_trace_satcnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_trace_capture.sv
// cache_trace_capture
//   Event capture beside the cache controller: records mm write transactions
//   into a circular trace buffer under arm/trigger control, keeps per-way
//   saturating hit counters and a sticky multi-hit error flag.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     ev_valid/addr/data  mm write event tap
//     hit_valid, way_hit  lookup result tap (way_hit expected one-hot)
//     arm, trig           control pulses (arm clears the buffer and wins over trig)
//     rd_idx -> rd_addr/rd_data  registered readout, index 0 = oldest entry
//     cnt_sel -> hit_cnt  combinational hit counter readout
//     count, wrapped, frozen, multi_hit_err  status
//   Optional macro CACHE_TRACE_STATE_LOG_EN adds fsm_state (ST_W bits) and
//   rd_is_state: controller state changes while capturing are logged as
//   tagged entries.
module cache_trace_capture
    import cache_trace_pkg::*;
#(
    parameter int WAYS      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST      = 4,
    parameter int CNT_W     = 16,
    parameter int WRAP_MODE = 1
`ifdef CACHE_TRACE_STATE_LOG_EN
    ,
    parameter int ST_W      = 4
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ev_valid,
    input  logic [ADDR_W-1:0]          ev_addr,
    input  logic [DATA_W-1:0]          ev_data,
    input  logic                       hit_valid,
    input  logic [WAYS-1:0]            way_hit,
    input  logic                       arm,
    input  logic                       trig,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
`ifdef CACHE_TRACE_STATE_LOG_EN
    input  logic [ST_W-1:0]            fsm_state,
    output logic                       rd_is_state,
`endif
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    input  logic [$clog2(WAYS)-1:0]    cnt_sel,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       wrapped,
    output logic                       frozen,
    output logic                       multi_hit_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = AW + 1;

    typedef struct packed {
`ifdef CACHE_TRACE_STATE_LOG_EN
        logic              tag;
`endif
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrapped_q, wrapped_d;
    logic [PW-1:0] post_q, post_d;
    logic          mhe_q, mhe_d;
    entry_t        rd_q;
    entry_t        mem_q [DEPTH];

    logic          capturing, full, req, we;
    entry_t        wentry;
    logic [AW-1:0] rd_phys;

    assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign full      = (count_q == CW'(DEPTH));

    // ------------------------------------------------------------------
    // Write source selection
    // ------------------------------------------------------------------
`ifdef CACHE_TRACE_STATE_LOG_EN
    logic [ST_W-1:0] st_prev_q, pend_st_q, pend_st_d;
    logic            pend_q, pend_d, st_chg;

    assign st_chg = capturing && (fsm_state != st_prev_q);

    // An mm event always goes first; a state change that collides with it
    // waits one cycle in the pending register. A newer change replaces a
    // pending one, so only the latest state is logged.
    always_comb begin
        req       = 1'b0;
        wentry    = '0;
        pend_d    = 1'b0;
        pend_st_d = pend_st_q;
        if (capturing && !arm) begin
            if (ev_valid) begin
                req         = 1'b1;
                wentry.addr = ev_addr;
                wentry.data = ev_data;
                pend_d      = pend_q | st_chg;
                if (st_chg) pend_st_d = fsm_state;
            end else if (pend_q) begin
                req         = 1'b1;
                wentry.tag  = 1'b1;
                wentry.data = DATA_W'(st_chg ? fsm_state : pend_st_q);
            end else if (st_chg) begin
                req         = 1'b1;
                wentry.tag  = 1'b1;
                wentry.data = DATA_W'(fsm_state);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_prev_q <= '0;
            pend_st_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            st_prev_q <= fsm_state;
            pend_st_q <= pend_st_d;
            pend_q    <= pend_d;
        end
    end

    assign rd_is_state = rd_q.tag;
`else
    always_comb begin
        req    = ev_valid;
        wentry = '0;
        if (ev_valid) begin
            wentry.addr = ev_addr;
            wentry.data = ev_data;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Capture FSM and buffer bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        post_d    = post_q;
        we        = 1'b0;
        if (arm) begin
            // arm wins over trig and over a same-cycle capture
            state_d   = ST_ARMED;
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
            post_d    = PW'(POST);
        end else begin
            if (capturing && req) begin
                if ((state_q == ST_ARMED) && full && (WRAP_MODE == 0)) begin
                    state_d = ST_FROZEN;
                end else begin
                    // POST always overwrites when full, whatever WRAP_MODE says
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (full) wrapped_d = 1'b1;
                    else      count_d   = count_q + CW'(1);
                    if (state_q == ST_POST) begin
                        post_d = post_q - PW'(1);
                        if (post_q == PW'(1)) state_d = ST_FROZEN;
                    end
                end
            end
            // The trig-cycle capture above ran in ARMED, so it is not a
            // post-trigger entry. A stop-when-full freeze takes precedence.
            if ((state_q == ST_ARMED) && trig && (state_d == ST_ARMED)) begin
                state_d = (POST == 0) ? ST_FROZEN : ST_POST;
                post_d  = PW'(POST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            post_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            post_q    <= post_d;
        end
    end

    // Trace RAM: not reset, reads are masked by count instead.
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_ptr_q] <= wentry;
    end

    // ------------------------------------------------------------------
    // Readout: once wrapped, the oldest entry sits at wr_ptr
    // ------------------------------------------------------------------
    assign rd_phys = (wrapped_q ? wr_ptr_q : '0) + rd_idx;

    always_ff @(posedge clk) begin
        if (reset)
            rd_q <= '0;
        else if ({1'b0, rd_idx} < count_q)
            rd_q <= mem_q[rd_phys];
        else
            rd_q <= '0;
    end

    assign rd_addr = rd_q.addr;
    assign rd_data = rd_q.data;

    // ------------------------------------------------------------------
    // Hit counters and multi-hit flag
    // ------------------------------------------------------------------
    logic                        hit_one;
    logic [WAYS-1:0][CNT_W-1:0]  cnt_all;

    assign hit_one = onehot_chk(64'(way_hit));

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_trace_satcnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr_i (1'b0),
            .inc_i (hit_valid && hit_one && way_hit[g]),
            .cnt_o (cnt_all[g])
        );
    end

    assign hit_cnt = cnt_all[cnt_sel];

    always_comb begin
        mhe_d = mhe_q;
        if (hit_valid && (way_hit != '0) && !hit_one) mhe_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) mhe_q <= 1'b0;
        else       mhe_q <= mhe_d;
    end

    assign count         = count_q;
    assign wrapped       = wrapped_q;
    assign frozen        = (state_q == ST_FROZEN);
    assign multi_hit_err = mhe_q;

endmodule

// File: tb/tb_cache_trace_capture.sv
module tb_cache_trace_capture;

    localparam int WAYS  = 4;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
    localparam logic [31:0] DK = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ev_valid = 1'b0;
    logic [31:0] ev_addr = '0;
    logic [31:0] ev_data = '0;
    logic        hit_valid = 1'b0;
    logic [3:0]  way_hit = '0;
    logic        arm = 1'b0;
    logic        trig = 1'b0;
    logic [3:0]  rd_idx = '0;
    logic [31:0] rd_addr, rd_data;
    logic [1:0]  cnt_sel = '0;
    logic [CNT_W-1:0] hit_cnt;
    logic [4:0]  count;
    logic        wrapped, frozen, multi_hit_err;
`ifdef CACHE_TRACE_STATE_LOG_EN
    logic [3:0]  fsm_state = '0;
    logic        rd_is_state;
`endif

    cache_trace_capture #(
        .WAYS(WAYS), .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
        .POST(4), .CNT_W(CNT_W), .WRAP_MODE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .ev_valid(ev_valid), .ev_addr(ev_addr), .ev_data(ev_data),
        .hit_valid(hit_valid), .way_hit(way_hit),
        .arm(arm), .trig(trig),
        .rd_idx(rd_idx),
`ifdef CACHE_TRACE_STATE_LOG_EN
        .fsm_state(fsm_state), .rd_is_state(rd_is_state),
`endif
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cnt_sel(cnt_sel), .hit_cnt(hit_cnt),
        .count(count), .wrapped(wrapped), .frozen(frozen),
        .multi_hit_err(multi_hit_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } rd_exp_t;
    rd_exp_t sbq[$];

    typedef struct {
        int          idx;
        logic [31:0] ea;
    } rd_vec_t;

    typedef struct {
        logic       hv;
        logic [3:0] wh;
    } hit_vec_t;

    rd_vec_t  rd_tab[5];
    hit_vec_t hit_tab[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [31:0] a);
        ev_valid = 1'b1;
        ev_addr  = a;
        ev_data  = a ^ DK;
        cyc();
        ev_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic rd_check(input string nm, input int idx, input logic [31:0] ea, input logic [31:0] ed);
        rd_exp_t e;
        rd_idx = idx[3:0];
        sbq.push_back('{a: ea, d: ed});
        cyc();
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_addr"}, rd_addr, e.a);
            chk({nm, "_data"}, rd_data, e.d);
        end
    endtask

    task automatic chk_cnt(input string nm, input int w, input logic [63:0] exp);
        cnt_sel = w[1:0];
        #1;
        chk(nm, hit_cnt, exp);
    endtask

    initial begin
        rd_tab[0] = '{idx: 0,  ea: 32'h4};
        rd_tab[1] = '{idx: 1,  ea: 32'h5};
        rd_tab[2] = '{idx: 7,  ea: 32'hB};
        rd_tab[3] = '{idx: 12, ea: 32'h10};
        rd_tab[4] = '{idx: 15, ea: 32'h13};

        hit_tab[0] = '{hv: 1'b1, wh: 4'b0010};
        hit_tab[1] = '{hv: 1'b1, wh: 4'b0010};
        hit_tab[2] = '{hv: 1'b1, wh: 4'b0010};
        hit_tab[3] = '{hv: 1'b1, wh: 4'b1000};
        hit_tab[4] = '{hv: 1'b1, wh: 4'b0110};
        hit_tab[5] = '{hv: 1'b0, wh: 4'b0001};
        hit_tab[6] = '{hv: 1'b1, wh: 4'b0000};

        // ---------------- reset state ----------------
        cyc();
        cyc();
        chk("rst_count", count, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_frozen", frozen, 0);
        chk("rst_mhe", multi_hit_err, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        for (int w = 0; w < WAYS; w++) chk_cnt($sformatf("rst_cnt%0d", w), w, 0);

        // ---------------- 5 events ----------------
        pulse_arm();
        for (int i = 0; i < 5; i++) ev(32'h100 + 32'(i));
        chk("t1_count", count, 5);
        chk("t1_wrapped", wrapped, 0);
        rd_check("t1_rd0", 0, 32'h100, 32'h100 ^ DK);
        rd_check("t1_rd4", 4, 32'h104, 32'h104 ^ DK);
        rd_check("t1_rd5_empty", 5, 32'h0, 32'h0);

        // ---------------- wrap: 20 events into 16 entries ----------------
        pulse_arm();
        chk("t2_arm_count", count, 0);
        for (int i = 0; i < 20; i++) ev(32'(i));
        chk("t2_count", count, 16);
        chk("t2_wrapped", wrapped, 1);
        chk("t2_frozen", frozen, 0);
        for (int k = 0; k < 5; k++)
            rd_check($sformatf("t2_rd%0d", rd_tab[k].idx), rd_tab[k].idx,
                     rd_tab[k].ea, rd_tab[k].ea ^ DK);

        // ---------------- post-trigger capture ----------------
        pulse_arm();
        chk("t3_wrapped_clr", wrapped, 0);
        for (int i = 0; i < 3; i++) ev(32'h200 + 32'(i));
        trig = 1'b1;
        ev(32'hA);
        trig = 1'b0;
        chk("t3_trig_count", count, 4);
        for (int i = 0; i < 6; i++) begin
            ev(32'h300 + 32'(i));
            if (i < 3) chk($sformatf("t3_frozen_p%0d", i + 1), frozen, 0);
            if (i == 3) chk("t3_frozen_p4", frozen, 1);
        end
        chk("t3_frozen_end", frozen, 1);
        chk("t3_count", count, 8);
        rd_check("t3_rd3_trig", 3, 32'hA, 32'hA ^ DK);
        rd_check("t3_rd7_last", 7, 32'h303, 32'h303 ^ DK);
        rd_check("t3_rd8_empty", 8, 32'h0, 32'h0);
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        chk("t3_trig_ignored_frozen", frozen, 1);

        // ---------------- arm and trig together ----------------
        arm  = 1'b1;
        trig = 1'b1;
        cyc();
        arm  = 1'b0;
        trig = 1'b0;
        chk("t4_unfrozen", frozen, 0);
        for (int i = 0; i < 5; i++) ev(32'h400 + 32'(i));
        chk("t4_still_armed", frozen, 0);
        chk("t4_count5", count, 5);
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        for (int i = 0; i < 3; i++) ev(32'h500 + 32'(i));
        chk("t4_post_p3", frozen, 0);
        ev(32'h503);
        chk("t4_post_p4", frozen, 1);
        chk("t4_count9", count, 9);

        // ---------------- hit counters ----------------
        for (int k = 0; k < 7; k++) begin
            hit_valid = hit_tab[k].hv;
            way_hit   = hit_tab[k].wh;
            cyc();
        end
        hit_valid = 1'b0;
        way_hit   = '0;
        chk_cnt("t5_cnt0", 0, 0);
        chk_cnt("t5_cnt1", 1, 3);
        chk_cnt("t5_cnt2", 2, 0);
        chk_cnt("t5_cnt3", 3, 1);
        chk("t5_mhe", multi_hit_err, 1);
        hit_valid = 1'b1;
        way_hit   = 4'b0001;
        repeat (260) cyc();
        hit_valid = 1'b0;
        chk_cnt("t5_cnt0_sat", 0, 8'hFF);
        pulse_arm();
        chk_cnt("t5_cnt1_after_arm", 1, 3);
        chk("t5_mhe_after_arm", multi_hit_err, 1);

        // ---------------- reset mid-POST ----------------
        pulse_arm();
        ev(32'h600);
        ev(32'h601);
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        ev(32'h602);
        chk("t6_pre_count", count, 3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_count", count, 0);
        chk("t6_frozen", frozen, 0);
        chk("t6_wrapped", wrapped, 0);
        chk("t6_mhe", multi_hit_err, 0);
        for (int w = 0; w < WAYS; w++) chk_cnt($sformatf("t6_cnt%0d", w), w, 0);
        ev(32'h700);
        chk("t6_idle_no_capture", count, 0);
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        ev(32'h701);
        chk("t6_idle_trig_ignored", count, 0);
        chk("t6_idle_not_frozen", frozen, 0);
        rd_check("t6_rd0_empty", 0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
